// File: rtl/ps2_key_event_decoder_pkg.sv
// Shared scancode constants, decoder state encoding and the queued key event record
// used by the PS/2 set-2 key event decoder.
package ps2_key_event_decoder_pkg;

   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_BRK    = 8'hF0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CTRL   = 8'h14;
   localparam logic [7:0] SC_ALT    = 8'h11;
   localparam logic [7:0] SC_CAPS   = 8'h58;

   typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       brk;
      logic       upper;
   } key_evt_t;

   // Keyboard housekeeping bytes (BAT result, ACK, resend, errors) carry no key.
   function automatic logic is_discard(input logic [7:0] b);
      return b inside {8'h00, 8'hAA, 8'hE1, 8'hFA, 8'hFE, 8'hFF};
   endfunction

endpackage

// File: rtl/ps2_key_event_decoder_if.sv
// Scancode input strobe and ready/valid key event output of the decoder.
interface ps2_key_event_decoder_if;
   logic       code_valid;
   logic [7:0] code_data;
   logic       evt_valid;
   logic       evt_ready;
   logic [7:0] evt_code;
   logic       evt_ext;
   logic       evt_break;
   logic       evt_upper;

   modport master (
      output code_valid, code_data, evt_ready,
      input  evt_valid, evt_code, evt_ext, evt_break, evt_upper
   );

   modport slave (
      input  code_valid, code_data, evt_ready,
      output evt_valid, evt_code, evt_ext, evt_break, evt_upper
   );
endinterface

// File: rtl/ps2_key_event_decoder_sync_fifo.sv
// First-word fall-through synchronous FIFO; a push into a full FIFO is accepted
// when the head is being popped on the same edge.
module sync_fifo #(
   parameter int WIDTH = 11,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_data,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr, rd_ptr;
   logic             full, empty, push, pop;

   assign count     = wr_ptr - rd_ptr;
   assign full      = (count == (AW+1)'(DEPTH));
   assign empty     = (count == '0);
   assign pop       = out_ready && !empty;
   assign in_ready  = !full || out_ready;
   assign push      = in_valid && in_ready;
   assign out_valid = !empty;
   assign out_data  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= in_data;
   end
endmodule

// File: rtl/ps2_key_event_decoder.sv
// PS/2 set-2 front end: strips E0/F0 prefixes, tracks Shift/Ctrl/Alt/CapsLock
// and queues decoded key events for the character writer.
//
//   state     | meaning
//   S_IDLE    | no prefix pending
//   S_EXT     | E0 seen, waiting for extended key byte
//   S_BRK     | F0 seen, waiting for released key byte
//   S_EXT_BRK | E0 and F0 seen, waiting for extended released key byte
import ps2_key_event_decoder_pkg::*;

module ps2_key_event_decoder #(
   parameter int FIFO_DEPTH  = 8,
   parameter int EMIT_BREAK  = 0,
   parameter int EMIT_MODS   = 0,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic                        clk,
   input  logic                        rst,
   ps2_key_event_decoder_if.slave      bus,
   output logic                        caps_lock,
   output logic                        shift,
   output logic                        ctrl,
   output logic                        alt,
   output logic                        overflow,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYC);

   state_t        state, state_nxt;
   logic          term, term_ext, term_brk;
   logic [TW-1:0] tmo_cnt;
   logic          shift_l, shift_r, ctrl_l, ctrl_r, alt_l, alt_r, caps_held;
   logic          fake_shift, key_hit, is_mod, push_req, push_ok;
   key_evt_t      evt_in, evt_out;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      term      = 1'b0;
      term_ext  = 1'b0;
      term_brk  = 1'b0;
      if (bus.code_valid) begin
         case (state)
            S_IDLE: begin
               if (bus.code_data == SC_EXT)          state_nxt = S_EXT;
               else if (bus.code_data == SC_BRK)     state_nxt = S_BRK;
               else if (!is_discard(bus.code_data)) term      = 1'b1;
            end
            S_EXT: begin
               if (bus.code_data == SC_BRK) state_nxt = S_EXT_BRK;
               else if (bus.code_data != SC_EXT) begin
                  term      = 1'b1;
                  term_ext  = 1'b1;
                  state_nxt = S_IDLE;
               end
            end
            S_BRK: begin
               if (bus.code_data == SC_EXT) state_nxt = S_EXT_BRK;
               else if (bus.code_data != SC_BRK) begin
                  term      = 1'b1;
                  term_brk  = 1'b1;
                  state_nxt = S_IDLE;
               end
            end
            S_EXT_BRK: begin
               if (bus.code_data != SC_EXT && bus.code_data != SC_BRK) begin
                  term      = 1'b1;
                  term_ext  = 1'b1;
                  term_brk  = 1'b1;
                  state_nxt = S_IDLE;
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end else if (TIMEOUT_CYC != 0 && state != S_IDLE && tmo_cnt == TW'(1)) begin
         state_nxt = S_IDLE;
      end
   end

   // Reloaded by every byte; only counts down while a prefix is pending.
   always_ff @(posedge clk) begin
      if (rst)                                   tmo_cnt <= '0;
      else if (bus.code_valid)                   tmo_cnt <= TMO_LOAD;
      else if (state != S_IDLE && tmo_cnt != '0) tmo_cnt <= tmo_cnt - 1'b1;
   end

   // E0 12 / E0 59 are the keyboard's fake shifts around navigation keys.
   assign fake_shift = term_ext && (bus.code_data == SC_LSHIFT || bus.code_data == SC_RSHIFT);
   assign key_hit    = term && !fake_shift;
   assign is_mod     = term_ext ? (bus.code_data inside {SC_CTRL, SC_ALT})
                                : (bus.code_data inside {SC_LSHIFT, SC_RSHIFT, SC_CTRL, SC_ALT, SC_CAPS});
   assign push_req   = key_hit && (!term_brk || EMIT_BREAK != 0) && (!is_mod || EMIT_MODS != 0);

   assign shift = shift_l || shift_r;
   assign ctrl  = ctrl_l || ctrl_r;
   assign alt   = alt_l || alt_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         {shift_l, shift_r, ctrl_l, ctrl_r, alt_l, alt_r} <= '0;
         caps_held <= 1'b0;
         caps_lock <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         if (push_req && !push_ok) overflow <= 1'b1;
         if (key_hit && !term_ext) begin
            case (bus.code_data)
               SC_LSHIFT: shift_l <= !term_brk;
               SC_RSHIFT: shift_r <= !term_brk;
               SC_CTRL:   ctrl_l  <= !term_brk;
               SC_ALT:    alt_l   <= !term_brk;
               SC_CAPS: begin
                  // Typematic repeats arrive with caps_held set and must not re-toggle.
                  if (term_brk) caps_held <= 1'b0;
                  else begin
                     if (!caps_held) caps_lock <= !caps_lock;
                     caps_held <= 1'b1;
                  end
               end
               default: ;
            endcase
         end else if (key_hit) begin
            case (bus.code_data)
               SC_CTRL: ctrl_r <= !term_brk;
               SC_ALT:  alt_r  <= !term_brk;
               default: ;
            endcase
         end
      end
   end

   assign evt_in = '{code: bus.code_data, ext: term_ext, brk: term_brk, upper: caps_lock ^ shift};

   sync_fifo #(
      .WIDTH ($bits(key_evt_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (push_req),
      .in_ready  (push_ok),
      .in_data   (evt_in),
      .out_valid (bus.evt_valid),
      .out_ready (bus.evt_ready),
      .out_data  (evt_out),
      .count     (fifo_count)
   );

   assign bus.evt_code  = evt_out.code;
   assign bus.evt_ext   = evt_out.ext;
   assign bus.evt_break = evt_out.brk;
   assign bus.evt_upper = evt_out.upper;
endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Bench for the key event decoder: two instances (events filtered / everything emitted)
// fed the same byte stream, compared against a prefix-flag reference model.
module tb_ps2_key_event_decoder;
   localparam int TMO   = 40;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ps2_key_event_decoder_if bus0 ();
   ps2_key_event_decoder_if bus1 ();

   logic       caps0, shift0, ctrl0, alt0, ovf0;
   logic       caps1, shift1, ctrl1, alt1, ovf1;
   logic [3:0] cnt0, cnt1;

   ps2_key_event_decoder #(.FIFO_DEPTH(DEPTH), .EMIT_BREAK(0), .EMIT_MODS(0), .TIMEOUT_CYC(TMO)) dut0 (
      .clk(clk), .rst(rst), .bus(bus0), .caps_lock(caps0), .shift(shift0), .ctrl(ctrl0),
      .alt(alt0), .overflow(ovf0), .fifo_count(cnt0));

   ps2_key_event_decoder #(.FIFO_DEPTH(DEPTH), .EMIT_BREAK(1), .EMIT_MODS(1), .TIMEOUT_CYC(TMO)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1), .caps_lock(caps1), .shift(shift1), .ctrl(ctrl1),
      .alt(alt1), .overflow(ovf1), .fifo_count(cnt1));

   wire [10:0] head0 = {bus0.evt_code, bus0.evt_ext, bus0.evt_break, bus0.evt_upper};
   wire [10:0] head1 = {bus1.evt_code, bus1.evt_ext, bus1.evt_break, bus1.evt_upper};

   int total = 0;
   int bad   = 0;

   // reference model: pending prefix flags, held keys, expected queues
   bit         m_ext, m_brk, m_pend, m_caps, m_caps_held;
   int         m_idle;
   bit         m_held [6];   // lshift rshift lctrl rctrl lalt ralt
   bit         m_ovf  [2];
   logic [10:0] mq0[$], mq1[$], ex0[$], ex1[$], ob0[$], ob1[$];

   function automatic logic [3:0] m_mods();
      return {m_caps, m_held[0] | m_held[1], m_held[2] | m_held[3], m_held[4] | m_held[5]};
   endfunction

   task automatic model_clear();
      m_ext = 0; m_brk = 0; m_pend = 0; m_caps = 0; m_caps_held = 0; m_idle = 0;
      for (int i = 0; i < 6; i++) m_held[i] = 0;
      m_ovf[0] = 0; m_ovf[1] = 0;
      mq0.delete(); mq1.delete(); ex0.delete(); ex1.delete(); ob0.delete(); ob1.delete();
   endtask

   task automatic step(input bit v, input logic [7:0] d, input bit rdy);
      logic [10:0] ev;
      bit          emit0, emit1;
      int          kind;
      ev = '0; emit0 = 0; emit1 = 0; kind = -1;
      bus0.code_valid = v; bus0.code_data = d; bus0.evt_ready = rdy;
      bus1.code_valid = v; bus1.code_data = d; bus1.evt_ready = rdy;
      if (bus0.evt_valid === 1'b1 && rdy) ob0.push_back(head0);
      if (bus1.evt_valid === 1'b1 && rdy) ob1.push_back(head1);
      if (rdy && mq0.size() > 0) ex0.push_back(mq0.pop_front());
      if (rdy && mq1.size() > 0) ex1.push_back(mq1.pop_front());
      if (v) begin
         m_idle = 0;
         if (d == 8'hE0) begin m_ext = 1; m_pend = 1; end
         else if (d == 8'hF0) begin m_brk = 1; m_pend = 1; end
         else if (!m_pend && (d inside {8'h00, 8'hAA, 8'hE1, 8'hFA, 8'hFE, 8'hFF})) begin end
         else begin
            if (!(m_ext && (d == 8'h12 || d == 8'h59))) begin
               if (!m_ext) begin
                  case (d)
                     8'h12: kind = 0;  8'h59: kind = 1;  8'h14: kind = 2;
                     8'h11: kind = 4;  8'h58: kind = 6;  default: kind = -1;
                  endcase
               end else begin
                  case (d)
                     8'h14: kind = 3;  8'h11: kind = 5;  default: kind = -1;
                  endcase
               end
               ev    = {d, m_ext, m_brk, m_caps ^ (m_held[0] | m_held[1])};
               emit0 = !m_brk && kind < 0;
               emit1 = 1;
               if (kind >= 0 && kind < 6) m_held[kind] = !m_brk;
               else if (kind == 6) begin
                  if (m_brk) m_caps_held = 0;
                  else begin
                     if (!m_caps_held) m_caps = !m_caps;
                     m_caps_held = 1;
                  end
               end
            end
            m_ext = 0; m_brk = 0; m_pend = 0;
         end
      end else if (m_pend) begin
         m_idle++;
         if (m_idle == TMO) begin m_pend = 0; m_ext = 0; m_brk = 0; m_idle = 0; end
      end
      if (emit0) begin
         if (mq0.size() < DEPTH) mq0.push_back(ev); else m_ovf[0] = 1;
      end
      if (emit1) begin
         if (mq1.size() < DEPTH) mq1.push_back(ev); else m_ovf[1] = 1;
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      bus0.code_valid = 0; bus0.code_data = '0; bus0.evt_ready = 0;
      bus1.code_valid = 0; bus1.code_data = '0; bus1.evt_ready = 0;
      rst = 1;
      @(posedge clk); @(posedge clk); #1;
      rst = 0;
      model_clear();
   endtask

   task automatic drain();
      for (int i = 0; i < 3 * DEPTH && (mq0.size() + mq1.size()) > 0; i++) step(0, 8'h00, 1);
      step(0, 8'h00, 1);
      step(0, 8'h00, 1);
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if ({bus0.evt_valid, caps0, shift0, ctrl0, alt0, ovf0, cnt0} !== 10'd0) begin
         bad++; $display("FAIL reset_dut0: got %b required 0", {bus0.evt_valid, caps0, shift0, ctrl0, alt0, ovf0, cnt0});
      end
      total++;
      if ({bus1.evt_valid, caps1, shift1, ctrl1, alt1, ovf1, cnt1} !== 10'd0) begin
         bad++; $display("FAIL reset_dut1: got %b required 0", {bus1.evt_valid, caps1, shift1, ctrl1, alt1, ovf1, cnt1});
      end
   endtask

   task automatic test_make();
      do_reset();
      step(1, 8'h1C, 0);
      total++;
      if (bus0.evt_valid !== 1'b1) begin bad++; $display("FAIL make_latency: valid=%b required 1", bus0.evt_valid); end
      total++;
      if (head0 !== {8'h1C, 3'b000}) begin bad++; $display("FAIL make_head: got %h required %h", head0, {8'h1C, 3'b000}); end
      step(1, 8'hF0, 0);
      step(1, 8'h1C, 0);
      total++;
      if (cnt0 !== 4'd1) begin bad++; $display("FAIL break_dropped: count=%0d required 1", cnt0); end
      total++;
      if (cnt1 !== 4'd2) begin bad++; $display("FAIL break_kept: count=%0d required 2", cnt1); end
      drain();
      total++;
      if (ob1.size() !== 2 || ob1[1] !== {8'h1C, 3'b010}) begin
         bad++; $display("FAIL break_event: size=%0d required 2 with %h", ob1.size(), {8'h1C, 3'b010});
      end
   endtask

   task automatic test_shift();
      do_reset();
      step(1, 8'h12, 0);
      total++;
      if (shift0 !== 1'b1) begin bad++; $display("FAIL shift_press: got %b required 1", shift0); end
      step(1, 8'h1C, 0);
      step(1, 8'hF0, 0);
      total++;
      if (shift0 !== 1'b1) begin bad++; $display("FAIL shift_prefix_hold: got %b required 1", shift0); end
      step(1, 8'h12, 0);
      total++;
      if (shift0 !== 1'b0) begin bad++; $display("FAIL shift_release: got %b required 0", shift0); end
      step(1, 8'h1C, 0);
      step(1, 8'hE0, 0); step(1, 8'h14, 0); step(1, 8'hE0, 0); step(1, 8'h11, 0);
      total++;
      if ({ctrl0, alt0} !== 2'b11) begin bad++; $display("FAIL right_ctrl_alt: got %b required 11", {ctrl0, alt0}); end
      step(1, 8'hE0, 0); step(1, 8'hF0, 0); step(1, 8'h14, 0);
      total++;
      if ({ctrl0, alt0} !== 2'b01) begin bad++; $display("FAIL right_ctrl_release: got %b required 01", {ctrl0, alt0}); end
      drain();
      total++;
      if (ob0.size() !== 2 || ob0[0] !== {8'h1C, 3'b001} || ob0[1] !== {8'h1C, 3'b000}) begin
         bad++; $display("FAIL shift_upper: size=%0d required 2 with %h,%h", ob0.size(), {8'h1C, 3'b001}, {8'h1C, 3'b000});
      end
   endtask

   task automatic test_caps();
      do_reset();
      step(1, 8'h58, 0);
      total++;
      if (caps0 !== 1'b1) begin bad++; $display("FAIL caps_toggle: got %b required 1", caps0); end
      step(1, 8'h58, 0); step(1, 8'h58, 0);
      total++;
      if (caps0 !== 1'b1) begin bad++; $display("FAIL caps_repeat: got %b required 1", caps0); end
      step(1, 8'hF0, 0); step(1, 8'h58, 0);
      step(1, 8'h1C, 0);
      step(1, 8'h12, 0); step(1, 8'h1C, 0);
      step(1, 8'hF0, 0); step(1, 8'h12, 0);
      step(1, 8'h58, 0);
      total++;
      if (caps0 !== 1'b0) begin bad++; $display("FAIL caps_retoggle: got %b required 0", caps0); end
      drain();
      total++;
      if (ob0.size() !== 2 || ob0[0] !== {8'h1C, 3'b001} || ob0[1] !== {8'h1C, 3'b000}) begin
         bad++; $display("FAIL caps_upper: size=%0d required 2 with %h,%h", ob0.size(), {8'h1C, 3'b001}, {8'h1C, 3'b000});
      end
   endtask

   task automatic test_ext();
      do_reset();
      step(1, 8'hE0, 0); step(1, 8'hF0, 0); step(1, 8'h75, 0);
      total++;
      if (head1 !== {8'h75, 3'b110} || cnt0 !== 4'd0) begin
         bad++; $display("FAIL ext_break: head=%h cnt0=%0d required %h and 0", head1, cnt0, {8'h75, 3'b110});
      end
      step(1, 8'hE0, 0); step(1, 8'h12, 0); step(1, 8'hE0, 0); step(1, 8'h70, 0);
      total++;
      if (shift0 !== 1'b0) begin bad++; $display("FAIL fake_shift: shift=%b required 0", shift0); end
      total++;
      if (head0 !== {8'h70, 3'b100} || cnt1 !== 4'd2) begin
         bad++; $display("FAIL ext_make: head=%h cnt1=%0d required %h and 2", head0, cnt1, {8'h70, 3'b100});
      end
      drain();
   endtask

   task automatic test_overflow();
      logic [7:0] c [10];
      do_reset();
      for (int i = 0; i < 10; i++) c[i] = 8'($urandom_range(8'h15, 8'h50));
      for (int i = 0; i < 8; i++) step(1, c[i], 0);
      total++;
      if (cnt0 !== 4'd8 || ovf0 !== 1'b0) begin bad++; $display("FAIL fill: count=%0d ovf=%b required 8 0", cnt0, ovf0); end
      step(1, c[8], 1);
      total++;
      if (cnt0 !== 4'd8 || ovf0 !== 1'b0) begin bad++; $display("FAIL full_push_pop: count=%0d ovf=%b required 8 0", cnt0, ovf0); end
      step(1, c[9], 0);
      total++;
      if (cnt0 !== 4'd8 || ovf0 !== 1'b1 || bus0.evt_code !== c[1]) begin
         bad++; $display("FAIL overflow: count=%0d ovf=%b head=%h required 8 1 %h", cnt0, ovf0, bus0.evt_code, c[1]);
      end
      drain();
      total++;
      if (ob0.size() !== 9) begin bad++; $display("FAIL drain_size: got %0d required 9", ob0.size()); end
      for (int i = 0; i < 9 && i < ob0.size(); i++) begin
         total++;
         if (ob0[i][10:3] !== c[i]) begin bad++; $display("FAIL drain_order[%0d]: got %h required %h", i, ob0[i][10:3], c[i]); end
      end
      total++;
      if (ovf0 !== 1'b1 || cnt0 !== 4'd0) begin bad++; $display("FAIL sticky: ovf=%b count=%0d required 1 0", ovf0, cnt0); end
      do_reset();
      total++;
      if (ovf0 !== 1'b0) begin bad++; $display("FAIL ovf_reset: got %b required 0", ovf0); end
   endtask

   task automatic test_timeout();
      do_reset();
      step(1, 8'hE0, 0);
      repeat (TMO - 1) step(0, 8'h00, 0);
      step(1, 8'h1C, 0);
      total++;
      if (head0 !== {8'h1C, 3'b100}) begin bad++; $display("FAIL before_timeout: got %h required %h", head0, {8'h1C, 3'b100}); end
      drain();
      step(1, 8'hE0, 0);
      repeat (TMO) step(0, 8'h00, 0);
      step(1, 8'h1C, 0);
      total++;
      if (head0 !== {8'h1C, 3'b000}) begin bad++; $display("FAIL after_timeout: got %h required %h", head0, {8'h1C, 3'b000}); end
      drain();
      step(1, 8'h58, 0);
      step(1, 8'hF0, 0);
      do_reset();
      total++;
      if (caps0 !== 1'b0) begin bad++; $display("FAIL rst_caps: got %b required 0", caps0); end
      step(1, 8'h1C, 0);
      total++;
      if (head0 !== {8'h1C, 3'b000} || cnt0 !== 4'd1) begin
         bad++; $display("FAIL rst_prefix: head=%h count=%0d required %h 1", head0, cnt0, {8'h1C, 3'b000});
      end
      drain();
   endtask

   task automatic test_back_to_back();
      logic [7:0] pool [14] = '{8'hE0, 8'hF0, 8'h12, 8'h59, 8'h14, 8'h11, 8'h58,
                                8'h1C, 8'h75, 8'h70, 8'hAA, 8'h00, 8'hE1, 8'h32};
      logic [7:0] d;
      int         idx;
      do_reset();
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 59) == 0) begin
            repeat (TMO + 2) step(0, 8'h00, ($urandom_range(0, 2) != 0));
         end
         idx = $urandom_range(0, 14);
         d   = (idx == 14) ? 8'($urandom) : pool[idx];
         step(($urandom_range(0, 3) != 0), d, ($urandom_range(0, 2) != 0));
         total++;
         if ({caps0, shift0, ctrl0, alt0, ovf0, cnt0} !== {m_mods(), m_ovf[0], 4'(mq0.size())}) begin
            bad++; $display("FAIL rand_state0 @%0d: got %b required %b", n,
                            {caps0, shift0, ctrl0, alt0, ovf0, cnt0}, {m_mods(), m_ovf[0], 4'(mq0.size())});
         end
         total++;
         if ({caps1, shift1, ctrl1, alt1, ovf1, cnt1} !== {m_mods(), m_ovf[1], 4'(mq1.size())}) begin
            bad++; $display("FAIL rand_state1 @%0d: got %b required %b", n,
                            {caps1, shift1, ctrl1, alt1, ovf1, cnt1}, {m_mods(), m_ovf[1], 4'(mq1.size())});
         end
      end
      drain();
      total++;
      if (ob0.size() !== ex0.size() || ob1.size() !== ex1.size()) begin
         bad++; $display("FAIL rand_event_count: got %0d/%0d required %0d/%0d", ob0.size(), ob1.size(), ex0.size(), ex1.size());
      end
      for (int i = 0; i < ob0.size() && i < ex0.size(); i++) begin
         total++;
         if (ob0[i] !== ex0[i]) begin bad++; $display("FAIL rand_evt0[%0d]: got %h required %h", i, ob0[i], ex0[i]); end
      end
      for (int i = 0; i < ob1.size() && i < ex1.size(); i++) begin
         total++;
         if (ob1[i] !== ex1[i]) begin bad++; $display("FAIL rand_evt1[%0d]: got %h required %h", i, ob1[i], ex1[i]); end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_make();
      test_shift();
      test_caps();
      test_ext();
      test_overflow();
      test_timeout();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
